cache_dfp_arbiter: RTL and testbench
====================================

Name: cache_dfp_arbiter

Overview:
- Shares the single memory-side line port between the instruction cache and the data cache.
- Each cache presents a one-outstanding-request line interface: read fill or dirty write-back, 256-bit line, 32-byte-aligned address.
- Serializes requests with round-robin arbitration, registers the granted request onto the memory port, and routes the response back to the owner.
- Sits between both cache cores' dfp ports and the memory/burst adapter.

Parameters:
- ADDR_W, 32, line address width
- LINE_W, 256, line data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_dfp_addr  in  ADDR_W  I-cache line address (bits 4:0 ignored, forced to 0 on memory side)
- i_dfp_read  in  1  I-cache fill request
- i_dfp_write  in  1  I-cache write request (normally 0, still arbitrated)
- i_dfp_wdata  in  LINE_W  I-cache write line
- i_dfp_rdata  out  LINE_W  fill data to I-cache
- i_dfp_resp  out  1  completion to I-cache
- d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata, d_dfp_rdata, d_dfp_resp  same widths and meanings, data-cache side
- mem_addr  out  ADDR_W  memory request address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_wdata  out  LINE_W  memory write line
- mem_rdata  in  LINE_W  memory read line
- mem_resp  in  1  memory completion, one-cycle pulse

Behaviour:
- Reset (rst low, asynchronous) clears the following immediately:
  - state=IDLE, last_grant=D, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Because i_dfp_resp and d_dfp_resp are derived from state, they are 0 while in IDLE.
- Reset mid-transaction: any in-flight request is abandoned; memory side is reset together with the arbiter.
- Client contract:
  - Hold read/write, addr and wdata stable from assertion until the cycle resp=1.
  - Deassert in the cycle after resp.
  - At most one outstanding request per client.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE transitions:
  - A client is pending if read|write is asserted.
  - Only I pending -> GRANT_I.
  - Only D pending -> GRANT_D.
  - Both pending -> grant the client that is not last_grant; the first contention after reset goes to I.
  - On the transition edge, capture into the memory output registers: addr (low 5 bits zeroed), wdata, and direction.
  - Capture last_grant at the same edge.
- Direction:
  - write=1 -> mem_write=1, mem_read=0, even if read is also asserted (illegal combination; write wins).
  - Otherwise mem_read=1.
- Latency: a request seen in IDLE at edge N reaches the memory port from cycle N+1 (one registered cycle).
- GRANT_x behaviour:
  - mem_read/mem_write held at 1 and all memory outputs held stable until mem_resp=1.
  - In the mem_resp cycle, assert owner's resp=1 combinationally in that same cycle; non-owner resp stays 0.
  - Next state is IDLE, and mem_read/mem_write clear at that edge.
- Data routing: i_dfp_rdata and d_dfp_rdata are both driven from mem_rdata continuously; only resp qualifies it.
- Back-to-back: at least one IDLE cycle between transactions, which gives a minimum of 2 cycles from resp to the next mem request. A dcache write-back followed by its fill is therefore two arbitrated transactions, and I may be granted between them.
- Spurious mem_resp in IDLE: ignored; no client resp, no state change.
- Fairness: with continuous contention, grants strictly alternate; neither client waits more than one transaction.
- No combinational path from client inputs to mem_* outputs. Client resp depends combinationally only on state and mem_resp.

Test Plan:
- Single I fill at 0x0000_1004:
  - Expect mem_read=1 and mem_addr=0x0000_1000 one cycle after request.
  - Apply mem_resp with rdata={8{32'hA5A5_0001}} 4 cycles later.
  - Expect i_dfp_resp=1 in that same cycle with matching rdata; d_dfp_resp=0 throughout; mem_read=0 next cycle.
- Simultaneous I read 0x100 and D write 0x200 (wdata=all 0x3C) right after reset:
  - Expect I granted first.
  - After I's resp, expect one IDLE cycle, then mem_write=1, mem_addr=0x200, mem_wdata=all 0x3C.
  - Expect d_dfp_resp on the next mem_resp.
- Both clients re-requesting continuously for 4 transactions each: expect grant order I,D,I,D,I,D,I,D.
- D asserts read=1 and write=1 at 0x40: expect mem_write=1, mem_read=0.
- Reset driven low while in GRANT_D with mem_read=1:
  - Expect mem_read=0 before the next clock edge.
  - After release with both pending, expect I granted.
- mem_resp pulsed while IDLE with no requests: expect both resp=0, mem_read=mem_write=0, state stays IDLE.

Source files
------------

// File: rtl/cache_dfp_arbiter_if.sv
// Line-granular dfp port shared by the caches and the memory side:
// one outstanding read fill or write-back, completed by a single resp pulse.
interface cache_dfp_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    // Requester side: a cache core or the arbiter facing memory.
    modport master (
        output addr, read, write, wdata,
        input  rdata, resp
    );

    // Responder side: the arbiter facing a cache or the memory adapter.
    modport slave (
        input  addr, read, write, wdata,
        output rdata, resp
    );
endinterface

// File: rtl/cache_dfp_arbiter.sv
// Round-robin arbiter sharing one registered memory line port between the
// instruction cache and the data cache; responses route back to the owner.
module cache_dfp_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_dfp_arbiter_if.slave   icache,
    cache_dfp_arbiter_if.slave   dcache,
    cache_dfp_arbiter_if.master  mem
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(32'h1F);

    state_t            r_state;
    state_t            w_nextState;
    owner_t            r_lastGrant;

    logic              w_iPending;
    logic              w_dPending;
    logic              w_grantI;
    logic              w_grantD;

    logic [ADDR_W-1:0] w_selAddr;
    logic [LINE_W-1:0] w_selWdata;
    logic              w_selWrite;

    logic [ADDR_W-1:0] r_memAddr;
    logic [LINE_W-1:0] r_memWdata;
    logic              r_memRead;
    logic              r_memWrite;

    assign w_iPending = icache.read | icache.write;
    assign w_dPending = dcache.read | dcache.write;

    // Grants are only issued from IDLE, so every transaction is followed by
    // at least one IDLE cycle and contention is resolved against last grant.
    always_comb begin
        w_nextState = r_state;
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_iPending && w_dPending) begin
                    if (r_lastGrant == OWNER_D) begin
                        w_grantI = 1'b1;
                    end else begin
                        w_grantD = 1'b1;
                    end
                end else if (w_iPending) begin
                    w_grantI = 1'b1;
                end else if (w_dPending) begin
                    w_grantD = 1'b1;
                end

                if (w_grantI) begin
                    w_nextState = GRANT_I;
                end else if (w_grantD) begin
                    w_nextState = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem.resp) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign w_selAddr  = w_grantD ? dcache.addr  : icache.addr;
    assign w_selWdata = w_grantD ? dcache.wdata : icache.wdata;
    assign w_selWrite = w_grantD ? dcache.write : icache.write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lastGrant <= OWNER_D;
        end else begin
            r_state <= w_nextState;
            if (w_grantI) begin
                r_lastGrant <= OWNER_I;
            end else if (w_grantD) begin
                r_lastGrant <= OWNER_D;
            end
        end
    end

    // Memory outputs are purely registered; a write request wins over a
    // simultaneous read, and direction drops on the completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
        end else if (w_grantI || w_grantD) begin
            r_memAddr  <= w_selAddr & ~OFFSET_MASK;
            r_memWdata <= w_selWdata;
            r_memWrite <= w_selWrite;
            r_memRead  <= ~w_selWrite;
        end else if ((r_state != IDLE) && mem.resp) begin
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
        end
    end

    assign mem.addr  = r_memAddr;
    assign mem.wdata = r_memWdata;
    assign mem.read  = r_memRead;
    assign mem.write = r_memWrite;

    assign icache.rdata = mem.rdata;
    assign dcache.rdata = mem.rdata;
    assign icache.resp  = (r_state == GRANT_I) & mem.resp;
    assign dcache.resp  = (r_state == GRANT_D) & mem.resp;

endmodule

// File: tb/tb_cache_dfp_arbiter.sv
// Randomized bench for cache_dfp_arbiter against a transaction-level model of
// the two clients, the round-robin grant rule and a latency-varying memory.
module tb_cache_dfp_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cache_dfp_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) icIf ();
    cache_dfp_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dcIf ();
    cache_dfp_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) memIf ();

    cache_dfp_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .icache (icIf),
        .dcache (dcIf),
        .mem    (memIf)
    );

    int errorCount = 0;
    int checkCount = 0;

    // Client 0 is the I-cache, client 1 the D-cache.
    req_t cliReq[2];
    bit   cliActive[2];
    int   cliGap[2];

    bit                mBusy;
    int                mOwner;
    int                mLast;
    req_t              mReq;
    int                mLat;
    bit                memRespNow;
    logic [LINE_W-1:0] rdataNow;
    int                grantLog[$];

    int                autoMode;
    bit                spuriousOn;
    bit                forceSpurious;
    int                fixedLat;
    bit                useFixedRdata;
    logic [LINE_W-1:0] fixedRdata;

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                               input logic [LINE_W-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] randLine();
        logic [LINE_W-1:0] v;
        for (int w = 0; w < LINE_W / 32; w++) begin
            v[w*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    function automatic int pickOwner(input bit iPend, input bit dPend, input int last);
        if (iPend && dPend) return (last == 1) ? 0 : 1;
        if (iPend) return 0;
        return 1;
    endfunction

    function automatic int grantAt(input int idx);
        if (idx < grantLog.size()) return grantLog[idx];
        return -1;
    endfunction

    task automatic driveClients();
        icIf.addr  = cliReq[0].addr;
        icIf.wdata = cliReq[0].wdata;
        icIf.read  = cliActive[0] & cliReq[0].read;
        icIf.write = cliActive[0] & cliReq[0].write;
        dcIf.addr  = cliReq[1].addr;
        dcIf.wdata = cliReq[1].wdata;
        dcIf.read  = cliActive[1] & cliReq[1].read;
        dcIf.write = cliActive[1] & cliReq[1].write;
        memIf.resp  = memRespNow;
        memIf.rdata = rdataNow;
    endtask

    task automatic applyStimulus(input int c, input logic rd, input logic wr,
                                 input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata);
        cliReq[c].read  = rd;
        cliReq[c].write = wr;
        cliReq[c].addr  = addr;
        cliReq[c].wdata = wdata;
        cliActive[c]    = 1'b1;
        driveClients();
    endtask

    // One clock: update the model at the edge, drive the next cycle, check at negedge.
    task automatic stepCycle();
        @(posedge clk);
        if (mBusy) begin
            if (memRespNow) begin
                mBusy             = 1'b0;
                cliActive[mOwner] = 1'b0;
                cliGap[mOwner]    = (autoMode == 2) ? 1 : int'($urandom_range(1, 4));
            end
        end else if (cliActive[0] || cliActive[1]) begin
            mOwner = pickOwner(cliActive[0], cliActive[1], mLast);
            mLast  = mOwner;
            mReq   = cliReq[mOwner];
            mBusy  = 1'b1;
            grantLog.push_back(mOwner);
            mLat   = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
        end

        #1;
        memRespNow = 1'b0;
        rdataNow   = randLine();
        if (mBusy) begin
            if (mLat == 0) begin
                memRespNow = 1'b1;
                if (useFixedRdata) rdataNow = fixedRdata;
            end else begin
                mLat--;
            end
        end else if (forceSpurious || (spuriousOn && $urandom_range(0, 7) == 0)) begin
            memRespNow = 1'b1;
        end
        forceSpurious = 1'b0;

        for (int c = 0; c < 2; c++) begin
            if (!cliActive[c] && autoMode != 0) begin
                if (cliGap[c] > 0) begin
                    cliGap[c]--;
                end else if (autoMode == 2 || $urandom_range(0, 2) == 0) begin
                    cliReq[c].write = 1'($urandom_range(0, 1));
                    cliReq[c].read  = cliReq[c].write ? ($urandom_range(0, 3) == 0) : 1'b1;
                    cliReq[c].addr  = $urandom;
                    cliReq[c].wdata = randLine();
                    cliActive[c]    = 1'b1;
                end
            end
        end
        driveClients();

        @(negedge clk);
        checkOutput("mem_read", LINE_W'(memIf.read), LINE_W'(mBusy && !mReq.write));
        checkOutput("mem_write", LINE_W'(memIf.write), LINE_W'(mBusy && mReq.write));
        if (mBusy) begin
            checkOutput("mem_addr", LINE_W'(memIf.addr), LINE_W'({mReq.addr[ADDR_W-1:5], 5'b0}));
            checkOutput("mem_wdata", memIf.wdata, mReq.wdata);
        end
        checkOutput("i_resp", LINE_W'(icIf.resp), LINE_W'(mBusy && mOwner == 0 && memRespNow));
        checkOutput("d_resp", LINE_W'(dcIf.resp), LINE_W'(mBusy && mOwner == 1 && memRespNow));
        checkOutput("i_rdata", icIf.rdata, rdataNow);
        checkOutput("d_rdata", dcIf.rdata, rdataNow);
    endtask

    task automatic runUntilIdle(input int maxCycles);
        int  n = 0;
        bit  timedOut = 1'b0;
        while (mBusy || cliActive[0] || cliActive[1]) begin
            if (n >= maxCycles) begin
                timedOut = 1'b1;
                break;
            end
            stepCycle();
            n++;
        end
        stepCycle();
        checkOutput("drain_timeout", LINE_W'(timedOut), LINE_W'(0));
    endtask

    // Asserts reset between edges; memory outputs must clear before any clock.
    task automatic applyReset();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mem_read", LINE_W'(memIf.read), LINE_W'(0));
        checkOutput("rst_mem_write", LINE_W'(memIf.write), LINE_W'(0));
        checkOutput("rst_mem_addr", LINE_W'(memIf.addr), LINE_W'(0));
        checkOutput("rst_mem_wdata", memIf.wdata, LINE_W'(0));
        checkOutput("rst_i_resp", LINE_W'(icIf.resp), LINE_W'(0));
        checkOutput("rst_d_resp", LINE_W'(dcIf.resp), LINE_W'(0));
        mBusy        = 1'b0;
        mLast        = 1;
        memRespNow   = 1'b0;
        cliActive[0] = 1'b0;
        cliActive[1] = 1'b0;
        cliGap[0]    = 0;
        cliGap[1]    = 0;
        driveClients();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [LINE_W-1:0] line3c;
        int                n;

        rst_n         = 1'b0;
        autoMode      = 0;
        spuriousOn    = 1'b0;
        forceSpurious = 1'b0;
        fixedLat      = -1;
        useFixedRdata = 1'b0;
        fixedRdata    = {8{32'hA5A5_0001}};
        rdataNow      = '0;
        memRespNow    = 1'b0;
        mBusy         = 1'b0;
        mOwner        = 0;
        mLast         = 1;
        mLat          = 0;
        mReq          = '0;
        for (int c = 0; c < 2; c++) begin
            cliReq[c]    = '0;
            cliActive[c] = 1'b0;
            cliGap[c]    = 0;
        end
        driveClients();
        @(negedge clk);
        @(negedge clk);
        applyReset();

        $display("[TB] single I fill at 0x1004");
        fixedLat      = 4;
        useFixedRdata = 1'b1;
        grantLog.delete();
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_1004, '0);
        runUntilIdle(30);
        checkOutput("fill_grants", LINE_W'(grantLog.size()), LINE_W'(1));
        checkOutput("fill_owner", LINE_W'(grantAt(0)), LINE_W'(0));
        useFixedRdata = 1'b0;

        $display("[TB] simultaneous I read and D write after reset");
        applyReset();
        fixedLat = 2;
        line3c   = {32{8'h3C}};
        grantLog.delete();
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, '0);
        applyStimulus(1, 1'b0, 1'b1, 32'h0000_0200, line3c);
        runUntilIdle(30);
        checkOutput("contend_first", LINE_W'(grantAt(0)), LINE_W'(0));
        checkOutput("contend_second", LINE_W'(grantAt(1)), LINE_W'(1));

        $display("[TB] contention after an I grant goes to D");
        grantLog.delete();
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0500, '0);
        runUntilIdle(30);
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0600, '0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0700, '0);
        runUntilIdle(30);
        checkOutput("rr_first", LINE_W'(grantAt(1)), LINE_W'(1));
        checkOutput("rr_second", LINE_W'(grantAt(2)), LINE_W'(0));

        $display("[TB] continuous contention");
        applyReset();
        fixedLat = -1;
        grantLog.delete();
        autoMode = 2;
        applyStimulus(0, 1'b1, 1'b0, $urandom, '0);
        applyStimulus(1, 1'b1, 1'b0, $urandom, '0);
        n = 0;
        while (grantLog.size() < 8 && n < 200) begin
            stepCycle();
            n++;
        end
        autoMode = 0;
        runUntilIdle(40);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("alt_grant%0d", i), LINE_W'(grantAt(i)), LINE_W'(i % 2));
        end

        $display("[TB] D read and write together at 0x40");
        grantLog.delete();
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_0040, randLine());
        runUntilIdle(30);
        checkOutput("rw_grants", LINE_W'(grantLog.size()), LINE_W'(1));

        $display("[TB] reset during GRANT_D");
        fixedLat = 20;
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_3000, '0);
        n = 0;
        while (!mBusy && n < 10) begin
            stepCycle();
            n++;
        end
        stepCycle();
        stepCycle();
        checkOutput("pre_rst_mem_read", LINE_W'(memIf.read), LINE_W'(1));
        applyReset();
        fixedLat = -1;
        grantLog.delete();
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_4000, '0);
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_5000, '0);
        runUntilIdle(30);
        checkOutput("post_rst_first", LINE_W'(grantAt(0)), LINE_W'(0));

        $display("[TB] spurious mem_resp while idle");
        forceSpurious = 1'b1;
        stepCycle();
        stepCycle();
        grantLog.delete();
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0080, '0);
        runUntilIdle(30);
        checkOutput("spur_grants", LINE_W'(grantLog.size()), LINE_W'(1));

        $display("[TB] randomized traffic");
        autoMode   = 1;
        spuriousOn = 1'b1;
        for (int i = 0; i < 600; i++) begin
            stepCycle();
        end
        autoMode   = 0;
        spuriousOn = 1'b0;
        runUntilIdle(100);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
